redmule_tcdm_mem_model: RTL and testbench

Parametrised, multi-port, word-addressed TCDM memory model for RedMulE simulation benches. It replaces the fixed-latency dummy memory.
- Serves NPORTS request/response ports into one shared array.
- Programmable read latency.
- Per-port LFSR-driven stall injection.
- Per-port access counters.
- Sticky out-of-range error reporting.
It sits between redmule_wrap's TCDM master ports plus the core data port and the backing storage, loaded by $readmemh through hierarchical path `memory`.

---
 rtl/redmule_tcdm_mem_model_pkg.sv | 19 +
 rtl/redmule_tcdm_mem_model_if.sv | 18 +
 rtl/redmule_tcdm_mem_model_lfsr.sv | 38 +++
 rtl/redmule_tcdm_mem_model.sv | 189 ++++++++++++++++++
 tb/tb_redmule_tcdm_mem_model.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/redmule_tcdm_mem_model_pkg.sv
// Shared types and constants for the RedMulE TCDM memory model.
package redmule_mem_model_pkg;

    typedef logic [15:0] lfsr_t;
    typedef logic [31:0] cnt_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam lfsr_t       LFSR_TAPS = 16'hB400;
    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;
    localparam cnt_t        CNT_MAX   = '1;

    // Compare value against lfsr[9:0]; 100% cannot be expressed in 10 bits and is handled by the caller.
    function automatic logic [9:0] stall_thresh(input int unsigned pct);
        int unsigned t;
        t = (pct * 1024) / 100;
        return (t > 1023) ? 10'd1023 : t[9:0];
    endfunction

endpackage

// File: rtl/redmule_tcdm_mem_model_if.sv
// Multi-port TCDM request/response bundle; master drives requests, slave answers.
interface redmule_tcdm_mem_model_if #(
    parameter int unsigned NPORTS = 9,
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 32
);
    logic [NPORTS-1:0]                req;
    logic [NPORTS-1:0][AW-1:0]        add;
    logic [NPORTS-1:0]                wen;
    logic [NPORTS-1:0][DW/8-1:0]      be;
    logic [NPORTS-1:0][DW-1:0]        data;
    logic [NPORTS-1:0]                gnt;
    logic [NPORTS-1:0][DW-1:0]        r_data;
    logic [NPORTS-1:0]                r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/redmule_tcdm_mem_model_lfsr.sv
// Per-port stall generator: free-running 16-bit Galois LFSR compared against a percentage threshold.
// Latency: stall_o is combinational from the LFSR state; the LFSR steps every cycle.
// Backpressure: none; the caller qualifies stall_o.
module redmule_mem_lfsr
    import redmule_mem_model_pkg::*;
#(
    parameter int unsigned STALL_PCT = 0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  lfsr_t seed_i,
    output logic  stall_o
);

    localparam logic [9:0] THRESH    = stall_thresh(STALL_PCT);
    localparam bit         STALL_ALL = (STALL_PCT >= 100);

    lfsr_t lfsr_q, lfsr_d, seed_nz;

    always_comb begin
        seed_nz = (seed_i == '0) ? lfsr_t'(1) : seed_i;
        lfsr_d  = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lfsr_q <= seed_nz;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_o = STALL_ALL || (lfsr_q[9:0] < THRESH);

endmodule

// File: rtl/redmule_tcdm_mem_model.sv
// Multi-port word-addressed TCDM model; define REDMULE_MEM_MODEL_TRACE_EN for a per-access trace.
// Latency: r_valid exactly RD_LATENCY cycles after grant, fully pipelined per port.
// Backpressure: gnt withheld by enable_i=0 or LFSR stall; responses cannot be stalled.
module redmule_tcdm_mem_model
    import redmule_mem_model_pkg::*;
#(
    parameter int unsigned    NPORTS     = 9,
    parameter int unsigned    DW         = 32,
    parameter int unsigned    AW         = 32,
    parameter int unsigned    MEM_WORDS  = 49152,
    parameter logic [AW-1:0]  BASE_ADDR  = 32'h1c010000,
    parameter int unsigned    RD_LATENCY = 1,
    parameter int unsigned    STALL_PCT  = 0,
    parameter lfsr_t          LFSR_SEED  = 16'hACE1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        stallable_i,
    input  logic                        clear_cnt_i,
    redmule_tcdm_mem_model_if.slave     tcdm,
    output cnt_t [NPORTS-1:0]           cnt_rd_o,
    output cnt_t [NPORTS-1:0]           cnt_wr_o,
    output logic                        err_o,
    output logic [$clog2(NPORTS)-1:0]   err_port_o
);

    localparam int unsigned   BW    = DW / 8;
    localparam int unsigned   OFFS  = $clog2(BW);
    localparam int unsigned   IW    = $clog2(MEM_WORDS);
    localparam int unsigned   PW    = $clog2(NPORTS);
    localparam logic [AW-1:0] DEPTH = AW'(MEM_WORDS);

    logic [DW-1:0] memory [MEM_WORDS];

    logic [NPORTS-1:0]          stall, gnt, oor, rd_gnt, wr_gnt, mem_we, oor_hit;
    logic [NPORTS-1:0][AW-1:0]  idx;
    logic [NPORTS-1:0][DW-1:0]  rdata;

    logic [NPORTS-1:0][RD_LATENCY-1:0]          pv_q, pv_d;
    logic [NPORTS-1:0][RD_LATENCY-1:0][DW-1:0]  pd_q, pd_d;
    cnt_t [NPORTS-1:0]                          cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d;
    logic                                       err_q, err_d;
    logic [PW-1:0]                              err_port_q, err_port_d;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        localparam lfsr_t SEED = LFSR_SEED ^ lfsr_t'(p);

        redmule_mem_lfsr #(
            .STALL_PCT (STALL_PCT)
        ) i_lfsr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .seed_i  (SEED),
            .stall_o (stall[p])
        );

        assign tcdm.r_data[p]  = pd_q[p][RD_LATENCY-1];
        assign tcdm.r_valid[p] = pv_q[p][RD_LATENCY-1];
    end

    assign tcdm.gnt = gnt;

    // Decode and grant; out-of-range accesses are still granted so the master never deadlocks.
    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            idx[p]    = (tcdm.add[p] - BASE_ADDR) >> OFFS;
            oor[p]    = (tcdm.add[p] < BASE_ADDR) || (idx[p] >= DEPTH);
            gnt[p]    = tcdm.req[p] & enable_i & ~(stallable_i & stall[p]);
            rd_gnt[p] = gnt[p] & tcdm.wen[p];
            wr_gnt[p] = gnt[p] & ~tcdm.wen[p];
            mem_we[p] = wr_gnt[p] & ~oor[p];
            oor_hit[p] = gnt[p] & oor[p];
            rdata[p]  = oor[p] ? DW'(ERR_RDATA) : memory[idx[p][IW-1:0]];
        end
    end

    // Highest port is applied first so the lowest port's bytes land last and win.
    always_ff @(posedge clk_i) begin
        for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
            if (mem_we[p]) begin
                for (int unsigned b = 0; b < BW; b++) begin
                    if (tcdm.be[p][b]) begin
                        memory[idx[p][IW-1:0]][b*8 +: 8] <= tcdm.data[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        pv_d       = pv_q;
        pd_d       = pd_q;
        cnt_rd_d   = cnt_rd_q;
        cnt_wr_d   = cnt_wr_q;
        err_d      = err_q | (|oor_hit);
        err_port_d = err_port_q;

        for (int unsigned p = 0; p < NPORTS; p++) begin
            pv_d[p][0] = gnt[p];
            pd_d[p][0] = rd_gnt[p] ? rdata[p] : '0;
            for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                pv_d[p][s] = pv_q[p][s-1];
                pd_d[p][s] = pd_q[p][s-1];
            end

            if (clear_cnt_i) begin
                cnt_rd_d[p] = '0;
                cnt_wr_d[p] = '0;
            end else begin
                if (rd_gnt[p] && (cnt_rd_q[p] != CNT_MAX)) cnt_rd_d[p] = cnt_rd_q[p] + cnt_t'(1);
                if (wr_gnt[p] && (cnt_wr_q[p] != CNT_MAX)) cnt_wr_d[p] = cnt_wr_q[p] + cnt_t'(1);
            end
        end

        // Walk downward so the lowest erroring port is the one captured.
        if (!err_q) begin
            for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
                if (oor_hit[p]) err_port_d = PW'(p);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pv_q       <= '0;
            pd_q       <= '0;
            cnt_rd_q   <= '0;
            cnt_wr_q   <= '0;
            err_q      <= 1'b0;
            err_port_q <= '0;
        end else begin
            pv_q       <= pv_d;
            pd_q       <= pd_d;
            cnt_rd_q   <= cnt_rd_d;
            cnt_wr_q   <= cnt_wr_d;
            err_q      <= err_d;
            err_port_q <= err_port_d;
        end
    end

    assign cnt_rd_o   = cnt_rd_q;
    assign cnt_wr_o   = cnt_wr_q;
    assign err_o      = err_q;
    assign err_port_o = err_port_q;

`ifdef REDMULE_MEM_MODEL_TRACE_EN
    logic [63:0]                                cyc_q, cyc_d;
    logic [NPORTS-1:0][RD_LATENCY-1:0]          tr_rd_q, tr_rd_d;
    logic [NPORTS-1:0][RD_LATENCY-1:0][AW-1:0]  tr_add_q, tr_add_d;

    always_comb begin
        cyc_d    = cyc_q + 64'd1;
        tr_rd_d  = tr_rd_q;
        tr_add_d = tr_add_q;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            tr_rd_d[p][0]  = rd_gnt[p];
            tr_add_d[p][0] = tcdm.add[p];
            for (int unsigned s = 1; s < RD_LATENCY; s++) begin
                tr_rd_d[p][s]  = tr_rd_q[p][s-1];
                tr_add_d[p][s] = tr_add_q[p][s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_q    <= '0;
            tr_rd_q  <= '0;
            tr_add_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            tr_rd_q  <= tr_rd_d;
            tr_add_q <= tr_add_d;
            for (int unsigned p = 0; p < NPORTS; p++) begin
                if (wr_gnt[p]) begin
                    $display("[MEM] cyc=%0d p=%0d W addr=%h data=%h be=%h",
                             cyc_q, p, tcdm.add[p], tcdm.data[p], tcdm.be[p]);
                end
                if (pv_q[p][RD_LATENCY-1] && tr_rd_q[p][RD_LATENCY-1]) begin
                    $display("[MEM] cyc=%0d p=%0d R addr=%h data=%h be=%h",
                             cyc_q, p, tr_add_q[p][RD_LATENCY-1], pd_q[p][RD_LATENCY-1], {BW{1'b0}});
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_redmule_tcdm_mem_model.sv
// Directed bench: dut_a (latency 1, 50% stall capable, full depth), dut_b (latency 3, 1024 words).
module tb_redmule_tcdm_mem_model;

    localparam int NP = 9;
    localparam logic [31:0] BASE = 32'h1c010000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, stallable, clear_cnt;
    logic [NP-1:0][31:0] cnt_rd_a, cnt_wr_a, cnt_rd_b, cnt_wr_b;
    logic err_a, err_b;
    logic [3:0] err_port_a, err_port_b;

    int n_checks = 0;
    int n_errors = 0;

    redmule_tcdm_mem_model_if #(.NPORTS(NP), .DW(32), .AW(32)) bus_a ();
    redmule_tcdm_mem_model_if #(.NPORTS(NP), .DW(32), .AW(32)) bus_b ();

    redmule_tcdm_mem_model #(
        .NPORTS(NP), .RD_LATENCY(1), .STALL_PCT(50)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .stallable_i(stallable),
        .clear_cnt_i(clear_cnt), .tcdm(bus_a), .cnt_rd_o(cnt_rd_a), .cnt_wr_o(cnt_wr_a),
        .err_o(err_a), .err_port_o(err_port_a)
    );

    redmule_tcdm_mem_model #(
        .NPORTS(NP), .MEM_WORDS(1024), .RD_LATENCY(3), .STALL_PCT(0)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .stallable_i(stallable),
        .clear_cnt_i(clear_cnt), .tcdm(bus_b), .cnt_rd_o(cnt_rd_b), .cnt_wr_o(cnt_wr_b),
        .err_o(err_b), .err_port_o(err_port_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus_a.req = '0; bus_a.wen = '1; bus_a.be = '0; bus_a.data = '0; bus_a.add = '0;
        bus_b.req = '0; bus_b.wen = '1; bus_b.be = '0; bus_b.data = '0; bus_b.add = '0;
    endtask

    task automatic drv(input bit sel_b, input int p, input bit rd, input logic [31:0] addr,
                       input logic [31:0] dat, input logic [3:0] be);
        if (sel_b) begin
            bus_b.req[p] = 1'b1; bus_b.wen[p] = rd; bus_b.add[p] = addr;
            bus_b.data[p] = dat; bus_b.be[p] = be;
        end else begin
            bus_a.req[p] = 1'b1; bus_a.wen[p] = rd; bus_a.add[p] = addr;
            bus_a.data[p] = dat; bus_a.be[p] = be;
        end
    endtask

    logic [31:0] wdat [4];
    int gcnt [NP];
    int gcnt2 [NP];

    initial begin
        rst_n = 1'b0; enable = 1'b1; stallable = 1'b0; clear_cnt = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rvalid", bus_a.r_valid, '0);
        check_eq("rst_rdata0", bus_a.r_data[0], '0);
        check_eq("rst_cnt", cnt_rd_a[0], '0);
        check_eq("rst_err", err_a, '0);
        check_eq("rst_err_port", err_port_a, '0);
        rst_n = 1'b1;

        // Write then read back on port 0, latency 1
        drv(0, 0, 0, BASE, 32'h12345678, 4'hF);
        #1 check_eq("t1_wr_gnt", bus_a.gnt, 9'h001);
        @(negedge clk);
        check_eq("t1_wr_rvalid", bus_a.r_valid, 9'h001);
        check_eq("t1_wr_rdata", bus_a.r_data[0], '0);
        drv(0, 0, 1, BASE, '0, '0);
        #1 check_eq("t1_rd_gnt", bus_a.gnt, 9'h001);
        @(negedge clk);
        check_eq("t1_rd_rvalid", bus_a.r_valid, 9'h001);
        check_eq("t1_rd_rdata", bus_a.r_data[0], 32'h12345678);
        check_eq("t1_cnt_wr", cnt_wr_a[0], 1);
        check_eq("t1_cnt_rd", cnt_rd_a[0], 1);
        idle();
        @(negedge clk);
        check_eq("t1_rvalid_drop", bus_a.r_valid, '0);

        // enable_i low blocks grants and counting
        enable = 1'b0;
        drv(0, 0, 1, BASE, '0, '0);
        #1 check_eq("en_gnt", bus_a.gnt, '0);
        @(negedge clk);
        check_eq("en_rvalid", bus_a.r_valid, '0);
        check_eq("en_cnt", cnt_rd_a[0], 1);
        enable = 1'b1;
        idle();

        // Same-word conflicts
        drv(0, 0, 0, BASE + 4, 32'h11111111, 4'hF);
        @(negedge clk);
        idle();
        drv(0, 1, 0, BASE + 4, 32'hAAAAAAAA, 4'hF);
        drv(0, 4, 0, BASE + 4, 32'h55555555, 4'hF);
        drv(0, 5, 1, BASE + 4, '0, '0);
        #1 check_eq("t3_gnt", bus_a.gnt, 9'h032);
        @(negedge clk);
        check_eq("t3_old", bus_a.r_data[5], 32'h11111111);
        idle();
        drv(0, 6, 1, BASE + 4, '0, '0);
        @(negedge clk);
        check_eq("t3_new", bus_a.r_data[6], 32'hAAAAAAAA);
        idle();
        drv(0, 2, 0, BASE + 4, 32'hAAAAAAAA, 4'b1100);
        drv(0, 7, 0, BASE + 4, 32'h55555555, 4'hF);
        @(negedge clk);
        idle();
        drv(0, 0, 1, BASE + 4, '0, '0);
        @(negedge clk);
        check_eq("t3_bytewise", bus_a.r_data[0], 32'hAAAA5555);
        idle();

        // Partial write
        drv(0, 0, 0, BASE + 16, 32'h00000000, 4'hF);
        @(negedge clk);
        drv(0, 0, 0, BASE + 16, 32'hFFFFFFFF, 4'b0101);
        @(negedge clk);
        drv(0, 0, 1, BASE + 16, '0, '0);
        @(negedge clk);
        check_eq("t4_partial", bus_a.r_data[0], 32'h00FF00FF);
        idle();

        // Out-of-range below base, then just past the top
        check_eq("t6_err_pre", err_a, 1'b0);
        drv(0, 3, 1, 32'h1c000000, '0, '0);
        @(negedge clk);
        check_eq("t6_oor_rdata", bus_a.r_data[3], 32'hDEADBEEF);
        check_eq("t6_err", err_a, 1'b1);
        check_eq("t6_err_port", err_port_a, 4'd3);
        idle();
        drv(0, 1, 1, BASE + 32'h30000, '0, '0);
        @(negedge clk);
        check_eq("t6_oor_top", bus_a.r_data[1], 32'hDEADBEEF);
        check_eq("t6_err_port_hold", err_port_a, 4'd3);
        idle();

        // Latency 3 pipelined reads on dut_b port 2
        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'hC0DE0000 + 32'(k);
            idle();
            drv(1, 2, 0, BASE + 32'(4 * k), wdat[k], 4'hF);
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_eq($sformatf("t2_rvalid%0d", c), bus_b.r_valid[2], (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                check_eq($sformatf("t2_rdata%0d", c), bus_b.r_data[2], wdat[c-3]);
            end
            idle();
            if (c < 4) begin
                drv(1, 2, 1, BASE + 32'(4 * c), '0, '0);
                #1 check_eq($sformatf("t2_gnt%0d", c), bus_b.gnt[2], 1'b1);
            end
        end

        // dut_b depth boundary: last word in range, first word past it dropped
        @(negedge clk);
        drv(1, 1, 0, BASE + 32'hFFC, 32'h7777EEEE, 4'hF);
        @(negedge clk);
        check_eq("bnd_err_pre", err_b, 1'b0);
        idle();
        drv(1, 0, 0, BASE + 32'h1000, 32'hBAD0BAD0, 4'hF);
        drv(1, 1, 1, BASE + 32'hFFC, '0, '0);
        @(negedge clk);
        check_eq("bnd_err", err_b, 1'b1);
        check_eq("bnd_err_port", err_port_b, 4'd0);
        idle();
        drv(1, 2, 1, BASE, '0, '0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check_eq("bnd_last_rvalid", bus_b.r_valid[1], 1'b1);
        check_eq("bnd_last_rdata", bus_b.r_data[1], 32'h7777EEEE);
        @(negedge clk);
        check_eq("bnd_wr_dropped", bus_b.r_data[2], 32'hC0DE0000);

        // Stall injection: clear wins over a same-cycle access, then measure grant rate
        idle();
        stallable = 1'b0;
        clear_cnt = 1'b1;
        drv(0, 0, 1, BASE, '0, '0);
        @(negedge clk);
        clear_cnt = 1'b0;
        check_eq("t5_clr_rd", cnt_rd_a[0], '0);
        check_eq("t5_clr_wr", cnt_wr_a[0], '0);
        stallable = 1'b1;
        for (int p = 0; p < NP; p++) begin
            drv(0, p, 1, BASE, '0, '0);
            gcnt[p] = 0;
            gcnt2[p] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            #1;
            for (int p = 0; p < NP; p++) if (bus_a.gnt[p]) gcnt[p]++;
            @(negedge clk);
        end
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("t5_rate%0d", p), (gcnt[p] >= 4500 && gcnt[p] <= 5500), 1'b1);
            check_eq($sformatf("t5_cnt%0d", p), cnt_rd_a[p], 64'(gcnt[p]));
        end
        stallable = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            for (int p = 0; p < NP; p++) if (bus_a.gnt[p]) gcnt2[p]++;
            @(negedge clk);
        end
        for (int p = 0; p < NP; p++) begin
            check_eq($sformatf("t5_full%0d", p), 64'(gcnt2[p]), 100);
            check_eq($sformatf("t5_cnt_full%0d", p), cnt_rd_a[p], 64'(gcnt[p] + 100));
        end
        idle();

        // Reset while a dut_b read is in flight
        @(negedge clk);
        drv(1, 2, 1, BASE, '0, '0);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t6r_rvalid", bus_b.r_valid, '0);
        check_eq("t6r_err", err_a, 1'b0);
        check_eq("t6r_err_port", err_port_a, '0);
        check_eq("t6r_cnt_a", cnt_rd_a[0], '0);
        check_eq("t6r_cnt_b", cnt_rd_b[2], '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("t6r_flush%0d", c), bus_b.r_valid, '0);
        end
        drv(0, 0, 1, BASE, '0, '0);
        @(negedge clk);
        check_eq("t6r_mem_kept", bus_a.r_data[0], 32'h12345678);
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
